// File: rtl/cc_mir_sequencer_pkg.sv
// Shared definitions for the microprogram sequencer.
// Contents: datapath widths, MIR bit positions, COND encodings, FSM states,
//           and the fixed prefix bit of a decode-dispatch address.
package cc_mir_sequencer_pkg;

   localparam int DATAWIDTH_MIR       = 41;
   localparam int DATAWIDTH_CSADDR    = 11;
   localparam int DATAWIDTH_REG_FIELD = 6;
   localparam int DATAWIDTH_ALU_OP    = 4;
   localparam int DATAWIDTH_IR        = 32;
   localparam int DATAWIDTH_COND      = 3;

   // MIR layout, LSB position of each field
   localparam int MIR_A_LSB     = 35;
   localparam int MIR_AMUX      = 34;
   localparam int MIR_B_LSB     = 28;
   localparam int MIR_BMUX      = 27;
   localparam int MIR_C_LSB     = 21;
   localparam int MIR_CMUX      = 20;
   localparam int MIR_RD        = 19;
   localparam int MIR_WR        = 18;
   localparam int MIR_ALU_LSB   = 14;
   localparam int MIR_COND_LSB  = 11;
   localparam int MIR_JADDR_LSB = 0;

   typedef enum logic [2:0] {
      COND_INC    = 3'b000,
      COND_N      = 3'b001,
      COND_Z      = 3'b010,
      COND_V      = 3'b011,
      COND_C      = 3'b100,
      COND_IR13   = 3'b101,
      COND_DECODE = 3'b110,
      COND_JUMP   = 3'b111
   } cond_e;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_LOAD   = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEMW   = 3'd3,
      ST_HALTED = 3'd4
   } state_e;

   // Decode dispatch lands in the upper half of the control store
   localparam logic CS_DECODE_PREFIX = 1'b1;

endpackage

// File: rtl/cc_mir_sequencer_if.sv
// Bus between the sequencer and its surroundings (control-store ROM,
// IR/PSR sources, memory handshake, CC_MUX field consumers).
//   master : sequencer side (drives ROM address, MIR fields, strobes)
//   slave  : environment side (drives ROM data, IR, flags, ACK, HALT)
interface cc_mir_sequencer_if;
   import cc_mir_sequencer_pkg::*;

   logic [DATAWIDTH_CSADDR-1:0]    rom_addr;
   logic [DATAWIDTH_MIR-1:0]       rom_data;
   logic [DATAWIDTH_IR-1:0]        ir;
   logic [3:0]                     psr_nzvc;
   logic                           mem_ack;
   logic                           halt;
   logic [DATAWIDTH_REG_FIELD-1:0] a_field;
   logic [DATAWIDTH_REG_FIELD-1:0] b_field;
   logic [DATAWIDTH_REG_FIELD-1:0] c_field;
   logic                           amux;
   logic                           bmux;
   logic                           cmux;
   logic [DATAWIDTH_ALU_OP-1:0]    alu;
   logic                           rd;
   logic                           wr;
   logic                           exec;

   modport master (
      output rom_addr, a_field, b_field, c_field, amux, bmux, cmux, alu, rd, wr, exec,
      input  rom_data, ir, psr_nzvc, mem_ack, halt
   );

   modport slave (
      input  rom_addr, a_field, b_field, c_field, amux, bmux, cmux, alu, rd, wr, exec,
      output rom_data, ir, psr_nzvc, mem_ack, halt
   );

endinterface

// File: rtl/cc_mir_sequencer_next_addr.sv
// cc_next_addr_logic: combinational next control-store address.
//   csai      in  current control-store address
//   cond      in  MIR COND field
//   jaddr     in  MIR JADDR field
//   ir        in  instruction register
//   nzvc      in  PSR flags {n,z,v,c}
//   next_csai out next address; CSAI+1 for sequential or untaken branch
module cc_next_addr_logic
   import cc_mir_sequencer_pkg::*;
(
   input  logic [DATAWIDTH_CSADDR-1:0] csai,
   input  logic [DATAWIDTH_COND-1:0]   cond,
   input  logic [DATAWIDTH_CSADDR-1:0] jaddr,
   input  logic [DATAWIDTH_IR-1:0]     ir,
   input  logic [3:0]                  nzvc,
   output logic [DATAWIDTH_CSADDR-1:0] next_csai
);

   logic [DATAWIDTH_CSADDR-1:0] inc;
   logic                        unused_ir;

   // Plain 11-bit add: 2047 rolls over to 0
   assign inc       = csai + 11'd1;
   assign unused_ir = ^{ir[29:25], ir[18:14], ir[12:0]};

   always_comb begin
      next_csai = inc;
      case (cond_e'(cond))
         COND_N:      if (nzvc[3]) next_csai = jaddr;
         COND_Z:      if (nzvc[2]) next_csai = jaddr;
         COND_V:      if (nzvc[1]) next_csai = jaddr;
         COND_C:      if (nzvc[0]) next_csai = jaddr;
         COND_IR13:   if (ir[13])  next_csai = jaddr;
         // op / op3 dispatch, 4 words per decoded instruction
         COND_DECODE: next_csai = {CS_DECODE_PREFIX, ir[31:30], ir[24:19], 2'b00};
         COND_JUMP:   next_csai = jaddr;
         default:     next_csai = inc;
      endcase
   end

endmodule

// File: rtl/cc_mir_sequencer.sv
// cc_mir_sequencer: microprogram sequencer and MIR register.
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous reset, active low
//   bus    master modport: ROM address/data, IR, flags, memory handshake,
//          HALT request, MIR field outputs and RD/WR/EXEC strobes
// One microinstruction takes FETCH -> LOAD -> EXEC; a memory request parks
// in MEMW until ACK, and HALT parks in HALTED at the instruction boundary.
module cc_mir_sequencer
   import cc_mir_sequencer_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   cc_mir_sequencer_if.master   bus
);

   state_e                      state, state_nxt;
   logic [DATAWIDTH_CSADDR-1:0] csai, csai_nxt;
   logic [DATAWIDTH_MIR-1:0]    mir;
   logic                        mir_rd, mir_wr, mem_req;
   logic                        exec_s, rd_s, wr_s;

   // RD wins when both request bits are set
   assign mir_rd  = mir[MIR_RD];
   assign mir_wr  = mir[MIR_WR] & ~mir[MIR_RD];
   assign mem_req = mir[MIR_RD] | mir[MIR_WR];

   cc_next_addr_logic u_next_addr (
      .csai      (csai),
      .cond      (mir[MIR_COND_LSB +: DATAWIDTH_COND]),
      .jaddr     (mir[MIR_JADDR_LSB +: DATAWIDTH_CSADDR]),
      .ir        (bus.ir),
      .nzvc      (bus.psr_nzvc),
      .next_csai (csai_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_FETCH;
         csai  <= '0;
         mir   <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_LOAD) mir  <= bus.rom_data;
         if (state == ST_EXEC) csai <= csai_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      exec_s    = 1'b0;
      rd_s      = 1'b0;
      wr_s      = 1'b0;
      case (state)
         ST_FETCH: state_nxt = ST_LOAD;
         ST_LOAD:  state_nxt = ST_EXEC;
         ST_EXEC: begin
            exec_s = 1'b1;
            rd_s   = mir_rd;
            wr_s   = mir_wr;
            if (mem_req)       state_nxt = ST_MEMW;
            else if (bus.halt) state_nxt = ST_HALTED;
            else               state_nxt = ST_FETCH;
         end
         ST_MEMW: begin
            rd_s = mir_rd;
            wr_s = mir_wr;
            if (bus.mem_ack) state_nxt = bus.halt ? ST_HALTED : ST_FETCH;
         end
         ST_HALTED: if (!bus.halt) state_nxt = ST_FETCH;
         default:   state_nxt = ST_FETCH;
      endcase
   end

   // ROM samples CSAI on the edge that ends FETCH
   assign bus.rom_addr = csai;
   assign bus.a_field  = mir[MIR_A_LSB +: DATAWIDTH_REG_FIELD];
   assign bus.amux     = mir[MIR_AMUX];
   assign bus.b_field  = mir[MIR_B_LSB +: DATAWIDTH_REG_FIELD];
   assign bus.bmux     = mir[MIR_BMUX];
   assign bus.c_field  = mir[MIR_C_LSB +: DATAWIDTH_REG_FIELD];
   assign bus.cmux     = mir[MIR_CMUX];
   assign bus.alu      = mir[MIR_ALU_LSB +: DATAWIDTH_ALU_OP];
   assign bus.exec     = exec_s;
   assign bus.rd       = rd_s;
   assign bus.wr       = wr_s;

endmodule

// File: tb/tb_cc_mir_sequencer.sv
// Bench for cc_mir_sequencer: ROM model, transaction-level reference thread
// checking every cycle, plus directed scenarios with literal expectations.
module tb_cc_mir_sequencer;
   import cc_mir_sequencer_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cc_mir_sequencer_if bus ();

   cc_mir_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [40:0] rom [0:2047];
   int checks = 0;
   int errors = 0;

   // Synchronous control store
   always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

   logic [24:0] dut_fields;
   assign dut_fields = {bus.a_field, bus.amux, bus.b_field, bus.bmux,
                        bus.c_field, bus.cmux, bus.alu};

   function automatic logic [40:0] mk(int a, int am, int b, int bm, int c, int cm,
                                      int rd, int wr, int alu, int cond, int j);
      return {6'(a), 1'(am), 6'(b), 1'(bm), 6'(c), 1'(cm), 1'(rd), 1'(wr),
              4'(alu), 3'(cond), 11'(j)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          mpc;
   logic [40:0] mw;

   function automatic int m_next(int pc, logic [40:0] w, logic [31:0] ir, logic [3:0] f);
      int inc;
      int j;
      inc = (pc + 1) % 2048;
      j   = int'(w[10:0]);
      case (w[13:11])
         3'd0:    return inc;
         3'd1:    return f[3] ? j : inc;
         3'd2:    return f[2] ? j : inc;
         3'd3:    return f[1] ? j : inc;
         3'd4:    return f[0] ? j : inc;
         3'd5:    return ir[13] ? j : inc;
         3'd6:    return 1024 + int'(ir[31:30]) * 256 + int'(ir[24:19]) * 4;
         default: return j;
      endcase
   endfunction

   task automatic chk_out(input string ph, input int addr, input logic e,
                          input logic r, input logic w, input logic [40:0] word);
      chk({ph, "_addr"},   32'(bus.rom_addr), 32'(addr));
      chk({ph, "_exec"},   32'(bus.exec), 32'(e));
      chk({ph, "_rd"},     32'(bus.rd), 32'(r));
      chk({ph, "_wr"},     32'(bus.wr), 32'(w));
      chk({ph, "_fields"}, 32'(dut_fields), 32'({word[40:20], word[17:14]}));
   endtask

   // Entered at the negedge of a FETCH cycle; leaves at the next FETCH
   // negedge, or returns early at a negedge seen under reset.
   task automatic run_instr();
      logic [40:0] w;
      logic        hs;
      int          n;
      chk_out("fetch", mpc, 1'b0, 1'b0, 1'b0, mw);
      @(negedge clk); if (!rst_n) return;
      chk_out("load", mpc, 1'b0, 1'b0, 1'b0, mw);
      @(negedge clk); if (!rst_n) return;
      w  = rom[mpc];
      mw = w;
      chk_out("exec", mpc, 1'b1, w[19], w[18] & ~w[19], w);
      hs  = bus.halt;
      mpc = m_next(mpc, w, bus.ir, bus.psr_nzvc);
      if (w[19] | w[18]) begin
         n = 0;
         forever begin
            @(negedge clk); if (!rst_n) return;
            chk_out("memw", mpc, 1'b0, w[19], w[18] & ~w[19], w);
            if (bus.mem_ack) begin hs = bus.halt; break; end
            n++;
            if (n > 500) begin chk("memw_timeout", 32'(n), 0); return; end
         end
      end
      if (hs) begin
         n = 0;
         forever begin
            @(negedge clk); if (!rst_n) return;
            chk_out("halted", mpc, 1'b0, 1'b0, 1'b0, w);
            if (!bus.halt) break;
            n++;
            if (n > 500) begin chk("halt_timeout", 32'(n), 0); return; end
         end
      end
      @(negedge clk);
   endtask

   initial begin : model
      mpc = 0;
      mw  = '0;
      @(negedge clk);
      forever begin
         if (!rst_n) begin
            mpc = 0;
            mw  = '0;
            chk_out("reset", 0, 1'b0, 1'b0, 1'b0, '0);
            @(negedge clk);
         end else begin
            run_instr();
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic wait_exec(input logic [10:0] addr, output bit found);
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.exec && bus.rom_addr == addr) begin found = 1'b1; break; end
      end
   endtask

   task automatic after_exec(input logic [10:0] from, input logic [10:0] to, input string nm);
      bit f;
      wait_exec(from, f);
      chk({nm, "_reach"}, 32'(f), 1);
      @(negedge clk);
      chk(nm, 32'(bus.rom_addr), 32'(to));
   endtask

   initial begin : stim
      bit f;
      int rdc;
      int exc;
      bus.ir       = 32'h8A00_4000;
      bus.psr_nzvc = 4'b0100;
      bus.mem_ack  = 1'b0;
      bus.halt     = 1'b0;
      for (int i = 0; i < 2048; i++) rom[i] = '0;
      rom[11'h001] = mk( 5, 1,  9, 0, 17, 1, 0, 0, 4'h3, 3'b010, 11'h040);
      rom[11'h040] = mk(33, 0,  2, 1, 60, 0, 0, 0, 4'hA, 3'b010, 11'h010);
      rom[11'h041] = mk( 1, 1,  1, 1,  1, 1, 0, 0, 4'h1, 3'b110, 11'h3AB);
      rom[11'h600] = mk(12, 0, 34, 1,  7, 0, 1, 0, 4'h5, 3'b111, 11'h7FF);
      rom[11'h7FF] = mk(63, 1, 63, 1, 63, 1, 0, 0, 4'hF, 3'b000, 11'h123);
      rom[11'h002] = mk( 3, 0,  4, 0,  5, 1, 0, 0, 4'h2, 3'b001, 11'h020);
      rom[11'h020] = mk( 8, 1,  0, 0, 22, 0, 0, 0, 4'h6, 3'b011, 11'h055);
      rom[11'h021] = mk( 9, 0, 10, 1, 11, 0, 0, 0, 4'h7, 3'b100, 11'h030);
      rom[11'h030] = mk(40, 1, 41, 0, 42, 1, 0, 0, 4'h8, 3'b101, 11'h050);
      rom[11'h031] = mk(13, 1, 14, 1, 15, 1, 1, 1, 4'h9, 3'b111, 11'h060);
      rom[11'h060] = mk(16, 0, 18, 0, 19, 0, 0, 1, 4'hB, 3'b111, 11'h070);
      rom[11'h070] = mk(50, 1, 51, 1, 52, 1, 1, 0, 4'hC, 3'b111, 11'h100);

      repeat (3) @(posedge clk);
      chk("rst_addr0", 32'(bus.rom_addr), 0);
      #1 rst_n = 1'b1;

      // first microinstruction: addresses 0,0,0 then 1, EXEC on cycle 3
      @(negedge clk); chk("c1_addr", 32'(bus.rom_addr), 0); chk("c1_exec", 32'(bus.exec), 0);
      @(negedge clk); chk("c2_addr", 32'(bus.rom_addr), 0); chk("c2_exec", 32'(bus.exec), 0);
      @(negedge clk); chk("c3_addr", 32'(bus.rom_addr), 0); chk("c3_exec", 32'(bus.exec), 1);
      @(negedge clk); chk("c4_addr", 32'(bus.rom_addr), 1); chk("c4_exec", 32'(bus.exec), 0);

      after_exec(11'h001, 11'h040, "br_z_taken");
      @(posedge clk); #1 bus.psr_nzvc = 4'b0000;
      after_exec(11'h040, 11'h041, "br_z_untaken");
      after_exec(11'h041, 11'h600, "decode");

      // RD with ACK arriving on the fourth wait cycle
      wait_exec(11'h600, f);
      chk("rd_reach", 32'(f), 1);
      rdc = int'(bus.rd);
      exc = int'(bus.exec);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (i == 3) bus.mem_ack = 1'b1;
         @(negedge clk);
         rdc += int'(bus.rd);
         exc += int'(bus.exec);
      end
      @(posedge clk); #1 bus.mem_ack = 1'b0; bus.halt = 1'b1;
      @(negedge clk);
      chk("rd_cycles", 32'(rdc), 5);
      chk("rd_exec_pulses", 32'(exc), 1);
      chk("ack_fetch_addr", 32'(bus.rom_addr), 32'h7FF);
      chk("ack_fetch_rd", 32'(bus.rd), 0);

      // wrap 2047 -> 0, then HALT
      after_exec(11'h7FF, 11'h000, "wrap");
      chk("halted_exec", 32'(bus.exec), 0);
      repeat (3) begin
         @(negedge clk);
         chk("halted_addr", 32'(bus.rom_addr), 0);
         chk("halted_strobes", 32'({bus.exec, bus.rd, bus.wr}), 0);
         chk("halted_a", 32'(bus.a_field), 63);
      end
      @(posedge clk); #1 bus.halt = 1'b0; bus.psr_nzvc = 4'b1001;

      after_exec(11'h000, 11'h001, "seq0");
      after_exec(11'h001, 11'h002, "br_z_untaken2");
      after_exec(11'h002, 11'h020, "br_n_taken");
      // stray ACK outside MEMW
      @(posedge clk); #1 bus.mem_ack = 1'b1;
      @(posedge clk); #1 bus.mem_ack = 1'b0;
      after_exec(11'h020, 11'h021, "br_v_untaken");
      after_exec(11'h021, 11'h030, "br_c_taken");
      after_exec(11'h030, 11'h031, "ir13_untaken");

      // RD and WR both set: only RD
      wait_exec(11'h031, f);
      chk("rdwr_reach", 32'(f), 1);
      chk("rdwr_rd", 32'(bus.rd), 1);
      chk("rdwr_wr", 32'(bus.wr), 0);
      @(posedge clk); #1 bus.mem_ack = 1'b1;
      @(negedge clk); chk("rdwr_memw_wr", 32'(bus.wr), 0);
      @(posedge clk); #1 bus.mem_ack = 1'b0;
      @(negedge clk); chk("rdwr_next", 32'(bus.rom_addr), 32'h060);

      // WR only
      wait_exec(11'h060, f);
      chk("wr_reach", 32'(f), 1);
      chk("wr_wr", 32'(bus.wr), 1);
      chk("wr_rd", 32'(bus.rd), 0);
      @(posedge clk); #1;
      @(posedge clk); #1 bus.mem_ack = 1'b1;
      @(posedge clk); #1 bus.mem_ack = 1'b0;
      @(negedge clk); chk("wr_next", 32'(bus.rom_addr), 32'h070);

      // reset in the middle of a memory wait
      wait_exec(11'h070, f);
      chk("mrst_reach", 32'(f), 1);
      @(posedge clk); #1;
      @(posedge clk); #1 chk("pre_rst_rd", 32'(bus.rd), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_rd", 32'(bus.rd), 0);
      chk("rst_fields", 32'(dut_fields), 0);
      chk("rst_addr", 32'(bus.rom_addr), 0);
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_addr", 32'(bus.rom_addr), 0);
      chk("post_rst_exec", 32'(bus.exec), 0);
      after_exec(11'h000, 11'h001, "post_rst_seq");
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
